button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 100_000_000: clock cycles from press to long-press, 1 s at 100 MHz; legal values are 2 or more.
REQ-002 Parameter REPEAT_CYCLES, default 20_000_000: clock cycles between auto-repeat pulses, 200 ms at 100 MHz; legal values are 2 or more.
REQ-003 Port clock  input  1  the single clock; all logic is on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port clean  input  1  debounced button level from the debounce block; 1 = pressed; synchronous to clock.
REQ-006 Port press  output  1  one-cycle pulse when a press is recognised.
REQ-007 Port release  output  1  one-cycle pulse when a recognised press ends.
REQ-008 Port short_click  output  1  one-cycle pulse with release when no long_press was issued for that press.
REQ-009 Port long_press  output  1  one-cycle pulse when the hold time reaches LONG_CYCLES.
REQ-010 Port repeat  output  1  one-cycle pulse every REPEAT_CYCLES after long_press while the button stays held.
REQ-011 Port held  output  1  level output; high while in state DOWN or LONG.

Function
REQ-012 All outputs SHALL be registered; latency from the edge that samples clean to the corresponding output is 1 clock, with the output valid in the cycle after that edge.
REQ-013 State machine states: DISARMED, IDLE, DOWN, LONG.
REQ-014 DISARMED: the block SHALL move to IDLE on the first edge that samples clean=0; no pulses are issued while DISARMED.
REQ-015 IDLE with clean=1: press pulse, counter cleared to 0, next state DOWN.
REQ-016 DOWN: the counter increments each cycle while clean=1; when it reaches LONG_CYCLES-1, the block issues a long_press pulse, clears the counter and moves to LONG.
REQ-017 LONG: the counter increments each cycle while clean=1; when it reaches REPEAT_CYCLES-1, the block issues a repeat pulse and clears the counter.
REQ-018 DOWN with clean=0: release and short_click pulses, next state IDLE.
REQ-019 LONG with clean=0: release pulse only, next state IDLE.
REQ-020 Release and terminal count on the same edge: release wins; long_press and repeat are suppressed on that edge; short_click follows REQ-018 and REQ-019 according to the current state.
REQ-021 Counter width SHALL be clog2 of max(LONG_CYCLES, REPEAT_CYCLES); the counter never wraps, because it is cleared at each terminal count.
REQ-022 At most one of press, long_press, repeat, release SHALL be high in any cycle; short_click is high only together with release.
REQ-023 The first long_press SHALL occur exactly LONG_CYCLES cycles after press; each repeat SHALL occur exactly REPEAT_CYCLES cycles after the preceding long_press or repeat.

Reset
REQ-024 While reset=1: state DISARMED, counter 0, and press, release, short_click, long_press, repeat, held all 0, independent of clock.
REQ-025 A button held through reset deassertion SHALL produce no press until it has been released and pressed again.
REQ-026 Reset asserted in mid-press SHALL abort the press with no release pulse; behaviour then follows REQ-025.

Structure
REQ-027 Package button_event_pkg SHALL hold the state enum type and the default LONG_CYCLES and REPEAT_CYCLES constants.
REQ-028 One sub-module, button_event_timer: a loadable up-counter with clear, enable and terminal-count compare, instantiated once and shared by DOWN and LONG.

Verification (bench parameters LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-029 clean high for 5 cycles then low -> press at cycle 1, release and short_click at cycle 6, no long_press.
REQ-030 clean high for 20 cycles -> press at cycle 1, long_press at cycle 9, repeat at cycles 13 and 17, release with short_click=0 at cycle 21.
REQ-031 clean falls on the edge where the counter reaches 7 -> release and short_click only; long_press stays 0.
REQ-032 clean=1 during and after reset release for 10 cycles, then low for 2 cycles, then high -> no pulses until the second rise; press one cycle after it.
REQ-033 Reset asserted at cycle 10 of a hold -> all outputs 0 immediately with no release pulse; held=0.
REQ-034 Random clean stream of 10k cycles -> checker confirms REQ-022 each cycle and the exact spacings of REQ-023.

Source files
------------

// File: rtl/button_event_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
// Shared definitions for the button_event block:
//   - state_e           : FSM state type for button_event
//   - DEF_LONG_CYCLES   : default hold time to long-press (1 s at 100 MHz)
//   - DEF_REPEAT_CYCLES : default auto-repeat period (200 ms at 100 MHz)
//   - cnt_width()       : counter width for a pair of cycle counts
// -----------------------------------------------------------------------------
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,  // waiting to see the button released after reset
    ST_IDLE     = 2'd1,  // released, ready for a press
    ST_DOWN     = 2'd2,  // pressed, timing towards long-press
    ST_LONG     = 2'd3   // long-press issued, timing auto-repeats
  } state_e;

  localparam int unsigned DEF_LONG_CYCLES   = 100_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 20_000_000;

  // The counter only ever needs to hold values up to max(a, b) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return unsigned'($clog2(m));
  endfunction

endpackage

// File: rtl/button_event_timer.sv
// -----------------------------------------------------------------------------
// button_event_timer
// Up-counter with synchronous clear, count enable and a compare against a
// terminal value supplied by the caller (the value is chosen per state, so one
// counter serves both the long-press and the auto-repeat timing).
// Ports:
//   clock_i  : clock, rising edge
//   reset_i  : asynchronous active-high reset, count goes to 0
//   clr_i    : clear count to 0 on next edge (wins over en_i)
//   en_i     : increment count on next edge
//   tc_val_i : terminal value to compare against
//   tc_o     : high while the current count equals tc_val_i
// -----------------------------------------------------------------------------
module button_event_timer
  import button_event_pkg::*;
#(
  parameter int unsigned W = cnt_width(DEF_LONG_CYCLES, DEF_REPEAT_CYCLES)
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == tc_val_i);

endmodule

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
// Turns a debounced button level into press / release / short-click /
// long-press / auto-repeat pulses plus a held level. All outputs are
// registered: they appear in the cycle after the edge that samples clean_i.
// Parameters:
//   LONG_CYCLES   : cycles from press to long-press (>= 2)
//   REPEAT_CYCLES : cycles between auto-repeat pulses (>= 2)
// Ports:
//   clock_i       : clock, rising edge
//   reset_i       : asynchronous active-high reset
//   clean_i       : debounced button level, 1 = pressed
//   press_o       : one-cycle pulse on a recognised press
//   release_o     : one-cycle pulse when a recognised press ends
//   short_click_o : with release_o when no long-press was issued
//   long_press_o  : one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_o      : one-cycle pulse every REPEAT_CYCLES after long-press
//   held_o        : level, high while the press is active
// -----------------------------------------------------------------------------
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clean_i,
  output logic press_o,
  output logic release_o,
  output logic short_click_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic held_o
);

  localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  // Terminal counts are one less than the period: the count starts at 0 on
  // the edge that enters DOWN/LONG, so reaching N-1 is exactly N cycles later.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  state_e state_q, state_d;

  logic press_q,   press_d;
  logic release_q, release_d;
  logic short_q,   short_d;
  logic long_q,    long_d;
  logic repeat_q,  repeat_d;
  logic held_q,    held_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_tc_val;

  button_event_timer #(
    .W (CNT_W)
  ) u_timer (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    // The counter sits at 0 unless a held button is being timed.
    tmr_clr    = 1'b1;
    tmr_en     = 1'b0;
    tmr_tc_val = LONG_TC;

    case (state_q)
      ST_DISARMED: begin
        if (!clean_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clean_i) begin
          press_d = 1'b1;
          state_d = ST_DOWN;
        end
      end
      ST_DOWN: begin
        tmr_tc_val = LONG_TC;
        // Release is tested first so it beats a coincident terminal count.
        if (!clean_i) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmr_tc) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      ST_LONG: begin
        tmr_tc_val = REPEAT_TC;
        if (!clean_i) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmr_tc) begin
          repeat_d = 1'b1;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      default: begin
        state_d = ST_DISARMED;
      end
    endcase

    held_d = (state_d == ST_DOWN) || (state_d == ST_LONG);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_DISARMED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_o       = press_q;
  assign release_o     = release_q;
  assign short_click_o = short_q;
  assign long_press_o  = long_q;
  assign repeat_o      = repeat_q;
  assign held_o        = held_q;

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
// Self-checking bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
// The reference model tracks only "armed", "pressed" and the number of edges
// since the press edge, and derives every output from those with arithmetic.
// -----------------------------------------------------------------------------
module tb_button_event;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst;
  logic clean;
  logic press_w, rel_w, sc_w, lp_w, rep_w, held_w;

  button_event #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .clean_i       (clean),
    .press_o       (press_w),
    .release_o     (rel_w),
    .short_click_o (sc_w),
    .long_press_o  (lp_w),
    .repeat_o      (rep_w),
    .held_o        (held_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // model state
  bit m_armed, m_pressed;
  int m_n;
  bit e_press, e_rel, e_sc, e_lp, e_rep, e_held;

  // bookkeeping
  int cyc, abs_cyc;
  int last_press_cyc, last_lr_cyc;
  int press_at, rel_at, sc_at, lp_at;
  int rep_at[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, abs_cyc);
  endtask

  task automatic model_update(input logic c);
    e_press = 0; e_rel = 0; e_sc = 0; e_lp = 0; e_rep = 0;
    if (rst) begin
      m_armed = 0; m_pressed = 0; m_n = 0;
    end else if (!m_armed) begin
      if (!c) m_armed = 1;
    end else if (!m_pressed) begin
      if (c) begin e_press = 1; m_pressed = 1; m_n = 0; end
    end else begin
      m_n++;
      if (c) begin
        if (m_n == L) e_lp = 1;
        else if (m_n > L && ((m_n - L) % R) == 0) e_rep = 1;
      end else begin
        e_rel = 1;
        e_sc = (m_n <= L);   // a long-press happened only if edge L saw clean=1
        m_pressed = 0;
      end
    end
    e_held = m_pressed && !rst;
  endtask

  task automatic compare();
    check("press", int'(press_w), int'(e_press));
    check("release", int'(rel_w), int'(e_rel));
    check("short_click", int'(sc_w), int'(e_sc));
    check("long_press", int'(lp_w), int'(e_lp));
    check("repeat", int'(rep_w), int'(e_rep));
    check("held", int'(held_w), int'(e_held));
    check("one_pulse", int'((int'(press_w) + int'(rel_w) + int'(lp_w) + int'(rep_w)) <= 1), 1);
    check("short_with_release", int'(!sc_w || rel_w), 1);
    if (press_w === 1'b1) last_press_cyc = abs_cyc;
    if (lp_w === 1'b1) begin
      check("long_spacing", abs_cyc - last_press_cyc, L);
      last_lr_cyc = abs_cyc;
    end
    if (rep_w === 1'b1) begin
      check("repeat_spacing", abs_cyc - last_lr_cyc, R);
      last_lr_cyc = abs_cyc;
    end
    if (press_w === 1'b1 && press_at < 0) press_at = cyc + 1;
    if (rel_w === 1'b1 && rel_at < 0) rel_at = cyc + 1;
    if (sc_w === 1'b1 && sc_at < 0) sc_at = cyc + 1;
    if (lp_w === 1'b1 && lp_at < 0) lp_at = cyc + 1;
    if (rep_w === 1'b1) rep_at.push_back(cyc + 1);
  endtask

  // Called just after a falling edge: drive clean, take the rising edge,
  // compare 1 time unit later, return at the next falling edge.
  task automatic step(input logic c);
    clean = c;
    @(posedge clk);
    model_update(c);
    #1;
    compare();
    cyc++;
    abs_cyc++;
    @(negedge clk);
  endtask

  task automatic start_scn();
    cyc = 0;
    press_at = -1; rel_at = -1; sc_at = -1; lp_at = -1;
    rep_at.delete();
  endtask

  int rep0, rep1;
  bit lvl;
  int remaining;

  initial begin
    rst = 1'b1;
    clean = 1'b0;
    m_armed = 0; m_pressed = 0; m_n = 0;
    abs_cyc = 0; last_press_cyc = 0; last_lr_cyc = 0;
    start_scn();
    @(negedge clk);
    repeat (3) step(1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0);

    // short click: 5 high then low
    start_scn();
    for (int i = 0; i < 5; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    check("short.press_at", press_at, 1);
    check("short.release_at", rel_at, 6);
    check("short.click_at", sc_at, 6);
    check("short.long_at", lp_at, -1);
    $display("short hold: press@%0d release@%0d click@%0d long@%0d", press_at, rel_at, sc_at, lp_at);

    // long hold: 20 high then low
    start_scn();
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    rep0 = (rep_at.size() > 0) ? rep_at[0] : -1;
    rep1 = (rep_at.size() > 1) ? rep_at[1] : -1;
    check("long.press_at", press_at, 1);
    check("long.long_at", lp_at, 9);
    check("long.repeat_count", rep_at.size(), 2);
    check("long.repeat0_at", rep0, 13);
    check("long.repeat1_at", rep1, 17);
    check("long.release_at", rel_at, 21);
    check("long.click_at", sc_at, -1);
    $display("long hold: press@%0d long@%0d repeats@%0d,%0d release@%0d", press_at, lp_at, rep0, rep1, rel_at);

    // release on the edge where the count reaches its terminal value
    start_scn();
    for (int i = 0; i < 8; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    check("tie.release_at", rel_at, 9);
    check("tie.click_at", sc_at, 9);
    check("tie.long_at", lp_at, -1);
    $display("release at terminal count: release@%0d click@%0d long@%0d", rel_at, sc_at, lp_at);

    // held through reset release
    rst = 1'b1;
    clean = 1'b1;
    repeat (2) step(1'b1);
    rst = 1'b0;
    start_scn();
    for (int i = 0; i < 10; i++) step(1'b1);
    for (int i = 0; i < 2; i++) step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    check("rearm.press_at", press_at, 13);
    $display("held through reset: first press@%0d", press_at);

    // reset in mid-press
    start_scn();
    for (int i = 0; i < 10; i++) step(1'b1);
    check("abort.press_at", press_at, 1);
    check("abort.held_before", int'(held_w), 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort.press", int'(press_w), 0);
    check("abort.release", int'(rel_w), 0);
    check("abort.short_click", int'(sc_w), 0);
    check("abort.long_press", int'(lp_w), 0);
    check("abort.repeat", int'(rep_w), 0);
    check("abort.held", int'(held_w), 0);
    @(negedge clk);
    repeat (2) step(1'b1);
    rst = 1'b0;
    check("abort.release_at", rel_at, -1);
    start_scn();
    for (int i = 0; i < 5; i++) step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < 2; i++) step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    check("abort.repress_at", press_at, 9);
    $display("reset mid-press: release@%0d next press@%0d", rel_at, press_at);

    // random runs of pressed / released
    start_scn();
    lvl = 1'b0;
    remaining = 0;
    for (int i = 0; i < 10000; i++) begin
      if (remaining == 0) begin
        lvl = !lvl;
        remaining = lvl ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
      end
      step(lvl);
      remaining--;
    end
    $display("random stream: 10000 cycles, %0d repeats seen", rep_at.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
